// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: addsub op codes, arbiter state encoding and
// default widths.
package alu_arbiter_pkg;

    localparam int unsigned L_DATA_DEF = 16;
    localparam int unsigned N_REQ_DEF  = 2;
    localparam int unsigned CTRL_W     = 3;

    typedef enum logic [CTRL_W-1:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_OR      = 3'b010,
        OP_AND     = 3'b011,
        OP_SLL     = 3'b100,
        OP_SRL     = 3'b101,
        OP_SLT     = 3'b110,
        OP_ILLEGAL = 3'b111
    } alu_op_e;

    // 2'd3 is never entered; the FSM treats it as IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    function automatic logic is_illegal(input logic [CTRL_W-1:0] ctrl);
        return ctrl == OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/ALU bundle of the shared-ALU arbiter; master is the requester/ALU side,
// slave is the arbiter.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned L_DATA = 16,
    parameter int unsigned N_REQ  = 2
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*L_DATA-1:0] op1_bus;
    logic [N_REQ*L_DATA-1:0] op2_bus;
    logic [N_REQ*CTRL_W-1:0] ctrl_bus;
    logic [L_DATA-1:0]       alu_out;
    logic [L_DATA-1:0]       alu_op1;
    logic [L_DATA-1:0]       alu_op2;
    logic [CTRL_W-1:0]       alu_ctrl;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic [L_DATA-1:0]       result;
    logic                    err;

    modport master (
        output req, op1_bus, op2_bus, ctrl_bus, alu_out,
        input  alu_op1, alu_op2, alu_ctrl, grant, done, result, err
    );

    modport slave (
        input  req, op1_bus, op2_bus, ctrl_bus, alu_out,
        output alu_op1, alu_op2, alu_ctrl, grant, done, result, err
    );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping
// at N_REQ.
module alu_arbiter_rr_pick #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win,
    output logic [PTR_W-1:0] win_idx,
    output logic             any
);

    // Pick the active requester with the smallest forward distance from rr_ptr
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        best_d  = N_REQ;
        d       = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            d = (i + N_REQ - 32'(rr_ptr)) % N_REQ;
            if (req[i] && (d < best_d)) begin
                best_d  = d;
                win     = '0;
                win[i]  = 1'b1;
                win_idx = PTR_W'(i);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one addsub ALU among N_REQ requesters with round-robin arbitration and a
// fixed IDLE -> EXEC -> RESP service per operation.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned L_DATA = L_DATA_DEF,
    parameter int unsigned N_REQ  = N_REQ_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  win_idx_q, win_idx_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              err_q, err_d;
    logic [L_DATA-1:0] result_q, result_d;
    logic [L_DATA-1:0] op1_q, op1_d;
    logic [L_DATA-1:0] op2_q, op2_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic [N_REQ-1:0]  pick_win;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;
    logic [L_DATA-1:0] sel_op1;
    logic [L_DATA-1:0] sel_op2;
    logic [CTRL_W-1:0] sel_ctrl;

    alu_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // Operand mux steered by the one-hot pick
    always_comb begin
        sel_op1  = '0;
        sel_op2  = '0;
        sel_ctrl = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_win[i]) begin
                sel_op1  = bus.op1_bus[i*L_DATA +: L_DATA];
                sel_op2  = bus.op2_bus[i*L_DATA +: L_DATA];
                sel_ctrl = bus.ctrl_bus[i*CTRL_W +: CTRL_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_idx_d = win_idx_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = 1'b0;
        result_d  = result_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        ctrl_d    = ctrl_q;

        case (state_q)
            ST_EXEC: begin
                // addsub holds its previous output on the illegal code, so never forward it
                result_d = is_illegal(ctrl_q) ? '0 : bus.alu_out;
                err_d    = is_illegal(ctrl_q);
                done_d   = grant_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                grant_d = '0;
                if (win_idx_q == PTR_W'(N_REQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = win_idx_q + PTR_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                if (pick_any) begin
                    op1_d     = sel_op1;
                    op2_d     = sel_op2;
                    ctrl_d    = sel_ctrl;
                    grant_d   = pick_win;
                    win_idx_d = pick_idx;
                    state_d   = ST_EXEC;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            win_idx_q <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            result_q  <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            win_idx_q <= win_idx_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            result_q  <= result_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign bus.alu_op1  = op1_q;
    assign bus.alu_op2  = op2_q;
    assign bus.alu_ctrl = ctrl_q;
    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.result   = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a 2-requester and a 4-requester instance, each
// driving a behavioural addsub.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned LD = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.L_DATA(LD), .N_REQ(2)) bus2 ();
    alu_arbiter_if #(.L_DATA(LD), .N_REQ(4)) bus4 ();

    alu_arbiter #(.L_DATA(LD), .N_REQ(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    alu_arbiter #(.L_DATA(LD), .N_REQ(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Behavioural addsub; 16'hDEAD stands in for the stale output on the illegal code
    function automatic logic [15:0] addsub_model(input logic [15:0] a, input logic [15:0] b,
                                                 input logic [2:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a | b;
            3'b011:  return a & b;
            3'b100:  return a << b[3:0];
            3'b101:  return a >> b[3:0];
            3'b110:  return {15'd0, $signed(a) < $signed(b)};
            default: return 16'hDEAD;
        endcase
    endfunction

    assign bus2.alu_out = addsub_model(bus2.alu_op1, bus2.alu_op2, bus2.alu_ctrl);
    assign bus4.alu_out = addsub_model(bus4.alu_op1, bus4.alu_op2, bus4.alu_ctrl);

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic        err;
        int          edge_n;
    } exp_t;

    exp_t q2[$];
    exp_t q4[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        int cnt;
        r   = -1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                cnt++;
                r = i;
            end
        end
        return (cnt == 1) ? r : -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // edge_n is the clock edge that closes the done cycle
    task automatic push(input bit four, input int idx, input logic [15:0] res,
                        input logic err, input int edge_n);
        exp_t e;
        e.idx    = idx;
        e.res    = res;
        e.err    = err;
        e.edge_n = edge_n;
        if (four) q4.push_back(e);
        else      q2.push_back(e);
    endtask

    task automatic check_out(input bit four, input logic [3:0] dn, input logic [15:0] res,
                             input logic er);
        exp_t e;
        int   act_idx;
        int   edge_now;
        n_vec++;
        edge_now = cyc + 1;
        act_idx  = onehot_idx(dn);
        if ((four && q4.size() == 0) || (!four && q2.size() == 0)) begin
            n_err++;
            $display("FAIL unexpected_done dut%0d: done=%b result=%h at edge %0d, expected no done",
                     four ? 4 : 2, dn, res, edge_now);
            return;
        end
        if (four) e = q4.pop_front();
        else      e = q2.pop_front();
        if (act_idx != e.idx || res !== e.res || er !== e.err || edge_now != e.edge_n) begin
            n_err++;
            $display("FAIL done_dut%0d: got idx=%0d result=%h err=%b edge=%0d expected idx=%0d result=%h err=%b edge=%0d",
                     four ? 4 : 2, act_idx, res, er, edge_now, e.idx, e.res, e.err, e.edge_n);
        end
    endtask

    always @(negedge clk) begin
        if (bus2.done !== 2'b00) check_out(1'b0, {2'b00, bus2.done}, bus2.result, bus2.err);
        if (bus4.done !== 4'b0000) check_out(1'b1, bus4.done, bus4.result, bus4.err);
    end

    task automatic set2(input int i, input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
        bus2.op1_bus[i*16 +: 16] = a;
        bus2.op2_bus[i*16 +: 16] = b;
        bus2.ctrl_bus[i*3 +: 3]  = c;
    endtask

    task automatic set4(input int i, input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
        bus4.op1_bus[i*16 +: 16] = a;
        bus4.op2_bus[i*16 +: 16] = b;
        bus4.ctrl_bus[i*3 +: 3]  = c;
    endtask

    // Step to the next done cycle (bounded); leaves the bench inside that cycle
    task automatic wait_done(input bit four);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            seen = four ? (bus4.done != 4'b0000) : (bus2.done != 2'b00);
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done_dut%0d: got no done in 20 cycles, expected a done pulse",
                     four ? 4 : 2);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n         = 1'b0;
        bus2.req      = 2'b11;
        bus2.op1_bus  = '0;
        bus2.op2_bus  = '0;
        bus2.ctrl_bus = '0;
        bus4.req      = 4'b0000;
        bus4.op1_bus  = '0;
        bus4.op2_bus  = '0;
        bus4.ctrl_bus = '0;
        set2(0, 16'd3, 16'd4, OP_ADD);
        set2(1, 16'h00F0, 16'h000F, OP_OR);

        // Reset held two cycles with both requests up
        step();
        step();
        chk("reset_grant", 32'(bus2.grant), 32'd0);
        chk("reset_done", 32'(bus2.done), 32'd0);
        chk("reset_result", 32'(bus2.result), 32'd0);
        chk("reset_err", 32'(bus2.err), 32'd0);
        chk("reset_alu_op1", 32'(bus2.alu_op1), 32'd0);
        chk("reset_alu_ctrl", 32'(bus2.alu_ctrl), 32'd0);

        // Contention right out of reset: 0,1,0,1 three cycles apart
        rst_n = 1'b1;
        t = cyc;
        push(0, 0, 16'd7,    1'b0, t + 3);
        push(0, 1, 16'h00FF, 1'b0, t + 6);
        push(0, 0, 16'd7,    1'b0, t + 9);
        push(0, 1, 16'h00FF, 1'b0, t + 12);
        step();
        chk("first_grant", 32'(bus2.grant), 32'd1);
        wait_done(0);
        wait_done(0);
        wait_done(0);
        wait_done(0);
        bus2.req = 2'b00;

        // Single SUB from req0
        step();
        set2(0, 16'd7, 16'd5, OP_SUB);
        bus2.req = 2'b01;
        t = cyc;
        push(0, 0, 16'd2, 1'b0, t + 3);
        step();
        chk("exec_alu_op1", 32'(bus2.alu_op1), 32'd7);
        chk("exec_alu_op2", 32'(bus2.alu_op2), 32'd5);
        chk("exec_alu_ctrl", 32'(bus2.alu_ctrl), 32'(OP_SUB));
        wait_done(0);
        chk("resp_grant", 32'(bus2.grant), 32'd1);
        bus2.req = 2'b00;

        // Pointer now at 1: req1 wins the tie
        step();
        set2(0, 16'hF0F0, 16'hFF00, OP_AND);
        set2(1, 16'h8000, 16'd15, OP_SRL);
        bus2.req = 2'b11;
        t = cyc;
        push(0, 1, 16'h0001, 1'b0, t + 3);
        push(0, 0, 16'hF000, 1'b0, t + 6);
        wait_done(0);
        wait_done(0);
        bus2.req = 2'b00;

        // Illegal op, then a legal wrapping ADD clears err
        step();
        set2(1, 16'd5, 16'd6, OP_ILLEGAL);
        bus2.req = 2'b10;
        t = cyc;
        push(0, 1, 16'h0000, 1'b1, t + 3);
        wait_done(0);
        bus2.req = 2'b00;
        step();
        set2(1, 16'hFFFF, 16'h0001, OP_ADD);
        bus2.req = 2'b10;
        t = cyc;
        push(0, 1, 16'h0000, 1'b0, t + 3);
        wait_done(0);
        bus2.req = 2'b00;

        step();
        set2(0, 16'd3, 16'd5, OP_SLT);
        bus2.req = 2'b01;
        t = cyc;
        push(0, 0, 16'h0001, 1'b0, t + 3);
        wait_done(0);
        bus2.req = 2'b00;

        // Reset during EXEC of SLL aborts; pointer returns to 0
        step();
        set2(0, 16'd1, 16'd4, OP_SLL);
        bus2.req = 2'b01;
        step();
        chk("abort_exec_grant", 32'(bus2.grant), 32'd1);
        rst_n    = 1'b0;
        bus2.req = 2'b00;
        step();
        chk("abort_grant", 32'(bus2.grant), 32'd0);
        chk("abort_done", 32'(bus2.done), 32'd0);
        chk("abort_result", 32'(bus2.result), 32'd0);
        rst_n = 1'b1;
        set2(1, 16'd5, 16'd7, OP_SUB);
        bus2.req = 2'b11;
        t = cyc;
        push(0, 0, 16'h0010, 1'b0, t + 3);
        push(0, 1, 16'hFFFE, 1'b0, t + 6);
        wait_done(0);
        wait_done(0);
        bus2.req = 2'b00;

        // Four requesters: serve 2, then 1001 goes to 3 and wraps to 0
        step();
        set4(2, 16'd1, 16'd1, OP_ADD);
        bus4.req = 4'b0100;
        t = cyc;
        push(1, 2, 16'd2, 1'b0, t + 3);
        wait_done(1);
        bus4.req = 4'b0000;
        step();
        set4(3, 16'h0F0F, 16'h00FF, OP_AND);
        set4(0, 16'd2, 16'd9, OP_SLT);
        bus4.req = 4'b1001;
        t = cyc;
        push(1, 3, 16'h000F, 1'b0, t + 3);
        push(1, 0, 16'h0001, 1'b0, t + 6);
        wait_done(1);
        wait_done(1);
        bus4.req = 4'b0000;

        step();
        step();
        step();
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
